// File: rtl/wb_writeback.sv
// wb_writeback -- writeback stage of the five-stage MIPS pipeline.
//
// This stage is the only driver of the GPR write port. It does three things:
//   1. Registers the MEM-stage result.
//   2. Extracts load data and applies sign or zero extension.
//   3. Shares the single write port between the pipeline and the
//      multiply/divide unit (MDU). The pipeline always wins; an MDU result
//      waits in a one-entry holding buffer until the port is free.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   ms_valid / ws_allowin    MEM -> WB handshake (WB never stalls)
//   ms_pc, ms_gr_we, ms_dest,
//   ms_result, ms_ld_type,
//   ms_rdata                 MEM instruction payload
//   mdu_valid / mdu_ready    MDU -> holding-buffer handshake
//   mdu_dest, mdu_result     MDU payload
//   rf_wen/rf_waddr/rf_wdata GPR write port
//   ws_fwd_*                 bypass of the pipeline write to ID
//   debug_wb_pc              PC in WB, or 0 when WB is empty
module wb_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        ms_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic        ms_gr_we,
    input  logic [4:0]  ms_dest,
    input  logic [31:0] ms_result,
    input  logic [2:0]  ms_ld_type,
    input  logic [31:0] ms_rdata,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_dest,
    input  logic [31:0] mdu_result,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        ws_fwd_valid,
    output logic [4:0]  ws_fwd_dest,
    output logic [31:0] ws_fwd_data,
    output logic [31:0] debug_wb_pc
);

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [2:0]  ld_type;
        logic [31:0] rdata;
    } ws_reg_t;

    ws_reg_t     ws;
    logic        ws_valid;
    logic        buf_valid;
    logic [4:0]  buf_dest;
    logic [31:0] buf_data;
    logic        buf_drain;
    logic        ws_wr;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // WB never back-pressures MEM. It refuses input only while reset is held.
    assign ws_allowin = !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws_valid <= 1'b0;
            ws       <= '0;
        end else begin
            ws_valid <= ms_valid && ws_allowin;
            if (ms_valid && ws_allowin)
                ws <= '{pc: ms_pc, gr_we: ms_gr_we, dest: ms_dest,
                        result: ms_result, ld_type: ms_ld_type, rdata: ms_rdata};
        end
    end

    // Load extraction. Halfword loads look only at the upper address bit,
    // because MEM has already trapped misaligned accesses.
    always_comb begin
        ld_byte = ws.rdata[7:0];
        case (ws.result[1:0])
            2'd0: ld_byte = ws.rdata[7:0];
            2'd1: ld_byte = ws.rdata[15:8];
            2'd2: ld_byte = ws.rdata[23:16];
            2'd3: ld_byte = ws.rdata[31:24];
            default: ld_byte = ws.rdata[7:0];
        endcase
        ld_half = ws.result[1] ? ws.rdata[31:16] : ws.rdata[15:0];
        case (ws.ld_type)
            3'd0:    ld_data = ws.result;
            3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    ld_data = {24'd0, ld_byte};
            3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {16'd0, ld_half};
            default: ld_data = ws.rdata;   // lw, and codes 6/7 alias lw
        endcase
    end

    // Port arbitration. When the pipeline writes the same register the
    // buffer holds, the buffered value is stale: the pipeline instruction is
    // younger. So the buffer entry is dropped instead of written later.
    always_comb begin
        ws_wr     = ws_valid && ws.gr_we;
        rf_wen    = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'd0;
        buf_drain = 1'b0;
        if (ws_wr) begin
            rf_wen    = (ws.dest != 5'd0);
            rf_waddr  = ws.dest;
            rf_wdata  = ld_data;
            buf_drain = buf_valid && (buf_dest == ws.dest);
        end else if (buf_valid) begin
            rf_wen    = (buf_dest != 5'd0);
            rf_waddr  = buf_dest;
            rf_wdata  = buf_data;
            buf_drain = 1'b1;
        end
    end

    // A draining entry frees the slot in the same cycle, so the MDU can
    // stream one result per cycle while the pipeline is idle.
    assign mdu_ready = !rst && (!buf_valid || buf_drain);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_dest  <= 5'd0;
            buf_data  <= 32'd0;
        end else if (mdu_valid && mdu_ready) begin
            buf_valid <= 1'b1;
            buf_dest  <= mdu_dest;
            buf_data  <= mdu_result;
        end else if (buf_drain) begin
            buf_valid <= 1'b0;
        end
    end

    // Only the pipeline write is forwarded. ID tracks MDU destinations itself.
    assign ws_fwd_valid = ws_wr && (ws.dest != 5'd0);
    assign ws_fwd_dest  = rf_waddr;
    assign ws_fwd_data  = rf_wdata;
    assign debug_wb_pc  = ws_valid ? ws.pc : 32'd0;

endmodule
